// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 64-bit architectural register file.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // XZR: always reads zero, writes to it are dropped
  localparam reg_addr_t ZERO_REG = reg_addr_t'(31);

endpackage

// File: rtl/regfile_2r1w_if.sv
// Write-back and operand-read bus between the pipeline and the register file.
interface regfile_2r1w_if;
  import regfile_pkg::*;

  logic      wr_en;
  reg_addr_t wr_addr;
  reg_data_t wr_data;
  reg_addr_t rd_addr_a;
  reg_addr_t rd_addr_b;
  reg_data_t rd_data_a;
  reg_data_t rd_data_b;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b
  );

endinterface

// File: rtl/bit_mux8.sv
// Single-bit 8:1 multiplexer, the leaf cell of the register read trees.
module bit_mux8 (
  input  logic [7:0] d_i,
  input  logic [2:0] sel_i,
  output logic       y_o
);

  assign y_o = d_i[sel_i];

endmodule

// File: rtl/regfile_read_port.sv
// One combinational read port: 8:1 leaf muxes plus a 4:1 final stage per bit,
// followed by same-cycle write forwarding and the zero-register override.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  reg_data_t regs_i [NUM_REGS],
  input  reg_addr_t rd_addr_i,
  input  logic      wr_en_i,
  input  reg_addr_t wr_addr_i,
  input  reg_data_t wr_data_i,
  output reg_data_t rd_data_o
);

  localparam int LEAVES = NUM_REGS / 8;

  reg_data_t tree_data;

  for (genvar b = 0; b < DATA_W; b++) begin : g_bit
    logic [LEAVES-1:0] leaf_out;

    for (genvar g = 0; g < LEAVES; g++) begin : g_leaf
      logic [7:0] col;

      for (genvar k = 0; k < 8; k++) begin : g_col
        assign col[k] = regs_i[8*g + k][b];
      end

      bit_mux8 u_mux (
        .d_i   (col),
        .sel_i (rd_addr_i[2:0]),
        .y_o   (leaf_out[g])
      );
    end

    assign tree_data[b] = leaf_out[rd_addr_i[ADDR_W-1:3]];
  end

  // Zero override last so it wins over forwarding; this also covers wr_addr == ZERO_REG.
  always_comb begin
    rd_data_o = tree_data;
    if (BYPASS_EN && wr_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_o = wr_data_i;
    end
    if (rd_addr_i == ZERO_REG) begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Architectural register file: storage, one-hot write decode and two read ports.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input logic            clk,
  input logic            reset,
  regfile_2r1w_if.slave  rf
);

  reg_data_t           regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_dec;
  logic                wr_fwd;

  always_comb begin
    wr_dec = '0;
    if (rf.wr_en) begin
      wr_dec[rf.wr_addr] = 1'b1;
    end
    wr_dec[ZERO_REG] = 1'b0;
  end

  // Forwarding is suppressed in reset so the ports read zero for every address.
  assign wr_fwd = rf.wr_en & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_dec[i]) begin
          regs_q[i] <= rf.wr_data;
        end
      end
    end
  end

  regfile_read_port #(.BYPASS_EN(BYPASS_EN)) u_port_a (
    .regs_i    (regs_q),
    .rd_addr_i (rf.rd_addr_a),
    .wr_en_i   (wr_fwd),
    .wr_addr_i (rf.wr_addr),
    .wr_data_i (rf.wr_data),
    .rd_data_o (rf.rd_data_a)
  );

  regfile_read_port #(.BYPASS_EN(BYPASS_EN)) u_port_b (
    .regs_i    (regs_q),
    .rd_addr_i (rf.rd_addr_b),
    .wr_en_i   (wr_fwd),
    .wr_addr_i (rf.wr_addr),
    .wr_data_i (rf.wr_data),
    .rd_data_o (rf.rd_data_b)
  );

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Architectural register file for the pipelined CPU: 32 x 64-bit registers, two combinational read ports, one synchronous write port.
- Sits downstream of the 8:1 bit-select muxes, which it instantiates as its read-port trees.
- Feeds operands to the ID/EX pipeline register; written from the WB stage.
- Register 31 is the zero register (XZR).

Parameters:
- DATA_W, 64, register width in bits.
- NUM_REGS, 32, number of architectural registers (fixed power of two).
- ADDR_W, 5, register index width (log2 NUM_REGS).
- ZERO_REG, 31, index that always reads 0 and ignores writes.
- BYPASS_EN, 1, 1 = write-to-read forwarding within the same cycle.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears all registers.
- wr_en  input  1  write enable from WB.
- wr_addr  input  ADDR_W  write register index.
- wr_data  input  DATA_W  write data.
- rd_addr_a  input  ADDR_W  read port A index (Rn).
- rd_addr_b  input  ADDR_W  read port B index (Rm/Rd for stores).
- rd_data_a  output  DATA_W  read port A data.
- rd_data_b  output  DATA_W  read port B data.

Behaviour:
- Reset:
  - reset low clears all NUM_REGS registers to 0 immediately, independent of clk.
  - While reset is low, rd_data_a and rd_data_b read 0 for every address.
  - Writes are blocked while reset is low.
  - Deassertion is synchronised externally; the first write is accepted on the first rising edge with reset high.
- Write:
  - On a rising edge with wr_en=1 and wr_addr != ZERO_REG, register[wr_addr] <= wr_data.
  - wr_en=0 leaves all registers unchanged.
  - wr_addr == ZERO_REG is silently dropped; the register never holds a nonzero value.
  - Write latency is 1 cycle; the stored value is visible on a plain read in the cycle after the edge.
- Read:
  - Purely combinational from rd_addr_x and register state, with 0 cycles of latency.
  - rd_addr_x == ZERO_REG returns 0 regardless of bypass.
  - Ports A and B are independent; both may address the same register.
- Bypass (BYPASS_EN=1):
  - If wr_en=1, wr_addr == rd_addr_x, and wr_addr != ZERO_REG, rd_data_x = wr_data in the same cycle, before the edge commits.
  - This resolves the WB→ID hazard without a separate forwarding path.
  - Bypass applies to A and B independently and simultaneously.
- Bypass (BYPASS_EN=0): reads return stored state only.
- Read-port structure:
  - Each port is a NUM_REGS:1 mux per bit, built as a tree of 8:1 bit muxes plus a 4:1 final stage.
  - The select is rd_addr; rd_addr[2:0] drives the first level.
- Write decode:
  - 5→32 one-hot decoder, gated by wr_en.
  - The ZERO_REG bit of the decoder output is forced low.
- Width rules:
  - No arithmetic; data passes unmodified.
  - Indices are unsigned; all ADDR_W-bit values are legal.
- X-handling: X on wr_addr while wr_en=1 is a bench assertion failure; the RTL needs no special handling.

Decomposition:
- Shared package regfile_pkg:
  - Holds DATA_W, ADDR_W, NUM_REGS and ZERO_REG constants.
  - Holds typedefs reg_addr_t (logic [ADDR_W-1:0]) and reg_data_t (logic [DATA_W-1:0]).
- One sub-module, regfile_read_port:
  - DATA_W-wide NUM_REGS:1 selector built from the existing 8:1 bit mux.
  - Contains the zero-register override and bypass compare.
  - Instantiated twice (A, B).
- Register storage and write decoder stay in the top module.

Test Plan:
1. Reset: write 64'hDEAD_BEEF_0000_0001 to X5, then pulse reset low mid-cycle (between edges) -> rd_data_a for X5 goes 0 immediately, asynchronously; a write attempted while reset is low leaves X5 = 0.
2. Basic write/read: write X0..X30 with value 64'h1000+i on successive edges -> after the last edge, reading each Xi on A and Xj on B returns 64'h1000+i and 64'h1000+j.
3. Zero register: wr_en=1, wr_addr=31, wr_data=64'hFFFF_FFFF_FFFF_FFFF -> rd_data_a at address 31 is 0 both before and after the edge, with no bypass.
4. Bypass: X7 holds 64'h11; in the same cycle set wr_en=1, wr_addr=7, wr_data=64'h22, rd_addr_a=rd_addr_b=7 -> both ports show 64'h22 before the edge. With BYPASS_EN=0 they show 64'h11 before the edge and 64'h22 after it.
5. Write disable: wr_en=0, wr_addr=3, wr_data=64'h55 for 4 edges -> X3 keeps its prior value 64'h1003.
6. Port independence: rd_addr_a=1 and rd_addr_b=30 while writing X30=64'hABCD -> A shows 64'h1001 unchanged; B shows 64'hABCD via bypass.
